// File: rtl/hv_pkg.sv
// rtl/hv_pkg.sv - opcodes and instruction field layout for the hypervector core
package hv_pkg;

    localparam int OP_W     = 4;
    localparam int OPND_W   = 12;
    localparam int INST_W   = OP_W + OPND_W;
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int OPND_MSB = 11;
    localparam int OPND_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_LXOR  = 4'd2,
        OP_WB    = 4'd3,
        OP_ROTR  = 4'd4,
        OP_ROTL  = 4'd5,
        OP_XOR   = 4'd6,
        OP_MOVE  = 4'd7,
        OP_SIGN  = 4'd8,
        OP_STORE = 4'd9,
        OP_LAST  = 4'd10
    } op_e;

    // Codes 11..15 are not enum members; they fall through to NOP in the decoder.
    function automatic op_e inst_op(input logic [INST_W-1:0] inst);
        return op_e'(inst[OP_MSB:OP_LSB]);
    endfunction

endpackage

// File: rtl/hv_core_pipe_if.sv
// rtl/hv_core_pipe_if.sv - instruction and result handshake bundle of the core
interface hv_core_pipe_if #(
    parameter int DIM = 1024
);

    logic            inst_valid;
    logic            inst_ready;
    logic [15:0]     inst;
    logic            out_valid;
    logic            out_ready;
    logic [DIM-1:0]  out_data;
    logic            done;

    // master: instruction distributor plus result box; slave: the core
    modport master (
        output inst_valid, inst, out_ready,
        input  inst_ready, out_valid, out_data, done
    );

    modport slave (
        input  inst_valid, inst, out_ready,
        output inst_ready, out_valid, out_data, done
    );

endinterface

// File: rtl/hv_rotator.sv
// rtl/hv_rotator.sv - combinational log2(DIM)-stage barrel rotator, dir=1 rotates left
module hv_rotator #(
    parameter int DIM = 1024
) (
    input  logic [DIM-1:0]         vec,
    input  logic [$clog2(DIM)-1:0] amt,
    input  logic                   dir,
    output logic [DIM-1:0]         res
);

    localparam int AMT_W = $clog2(DIM);

    logic [DIM-1:0] v;

    // Stage s rotates by 2**s when amt[s] is set; the loop unrolls into AMT_W mux levels.
    always_comb begin
        v = vec;
        for (int s = 0; s < AMT_W; s++) begin
            if (amt[s]) begin
                if (dir) begin
                    v = (v << (1 << s)) | (v >> (DIM - (1 << s)));
                end else begin
                    v = (v >> (1 << s)) | (v << (DIM - (1 << s)));
                end
            end
        end
        res = v;
    end

endmodule

// File: rtl/hv_core_pipe.sv
// rtl/hv_core_pipe.sv - two-stage hypervector core with item memory, rotator and stalling result buffer
module hv_core_pipe
    import hv_pkg::*;
#(
    parameter int  DIM    = 1024,
    parameter int  DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              gen_we,
    input  logic [ADDR_W-1:0] gen_addr,
    input  logic [DIM-1:0]    gen_data,
    input  logic [DIM-1:0]    sign_bit,
    hv_core_pipe_if.slave     bus
);

    localparam int AMT_W     = $clog2(DIM);
    localparam int OPND_KEEP = (ADDR_W > AMT_W) ? ADDR_W : AMT_W;

    logic [DIM-1:0] mem [DEPTH];

    op_e                  s1_op_q, s1_op_d;
    logic [OPND_KEEP-1:0] s1_opnd_q, s1_opnd_d;
    logic [DIM-1:0]       rd_data_q, rd_data_d;
    logic [DIM-1:0]       r1_q, r1_d;
    logic [DIM-1:0]       r2_q, r2_d;
    logic [DIM-1:0]       out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 done_q, done_d;
    logic                 rdy_en_q, rdy_en_d;

    op_e                  s0_op;
    logic [OPND_KEEP-1:0] s0_opnd;
    logic [ADDR_W-1:0]    s0_addr;
    logic [ADDR_W-1:0]    s1_addr;
    logic [AMT_W-1:0]     s1_amt;
    logic                 stall;
    logic                 accept;
    logic                 wb_en;
    logic [DIM-1:0]       rot_res;

    assign s0_op   = inst_op(bus.inst);
    assign s0_opnd = bus.inst[OPND_LSB +: OPND_KEEP];
    assign s0_addr = s0_opnd[ADDR_W-1:0];
    assign s1_addr = s1_opnd_q[ADDR_W-1:0];
    assign s1_amt  = s1_opnd_q[AMT_W-1:0];

    // A STORE waits for the buffer slot; a LAST waits until the buffer has fully drained.
    assign stall = ((s1_op_q == OP_STORE) && out_valid_q && !bus.out_ready)
                 || ((s1_op_q == OP_LAST) && out_valid_q);

    // rdy_en_q keeps inst_ready low through reset and for the first edge after it.
    assign bus.inst_ready = rdy_en_q && run && !stall;
    assign accept         = bus.inst_valid && bus.inst_ready;
    assign wb_en          = run && (s1_op_q == OP_WB);

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? out_data_q : '0;
    assign bus.done      = done_q;

    hv_rotator #(.DIM(DIM)) u_rot (
        .vec (r2_q),
        .amt (s1_amt),
        .dir (s1_op_q == OP_ROTL),
        .res (rot_res)
    );

    // WB owns the single write port; a gen_we in the same cycle is dropped.
    always_ff @(posedge clk) begin
        if (wb_en) begin
            mem[s1_addr] <= r2_q;
        end else if (gen_we) begin
            mem[gen_addr] <= gen_data;
        end
    end

    always_comb begin
        s1_op_d     = s1_op_q;
        s1_opnd_d   = s1_opnd_q;
        rd_data_d   = rd_data_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        rdy_en_d    = run;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (!stall) begin
            s1_op_d   = accept ? s0_op : OP_NOP;
            s1_opnd_d = s0_opnd;
            // A WB to the same address lands in memory only at this edge, so the
            // value it writes (current r2) is forwarded in place of the stale read.
            rd_data_d = (wb_en && (s1_addr == s0_addr)) ? r2_q : mem[s0_addr];
        end

        case (s1_op_q)
            OP_LOAD:  r2_d = rd_data_q;
            OP_LXOR:  r2_d = r2_q ^ rd_data_q;
            OP_ROTR,
            OP_ROTL:  r2_d = rot_res;
            OP_XOR:   r2_d = r1_q ^ r2_q;
            OP_MOVE:  r1_d = r2_q;
            OP_SIGN:  r2_d = sign_bit;
            OP_STORE: begin
                if (!stall) begin
                    out_data_d  = r2_q;
                    out_valid_d = 1'b1;
                end
            end
            OP_LAST: begin
                if (!stall) begin
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (!run) begin
            r1_d        = '0;
            r2_d        = '0;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
            s1_op_d     = OP_NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_op_q     <= OP_NOP;
            s1_opnd_q   <= '0;
            rd_data_q   <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            s1_op_q     <= s1_op_d;
            s1_opnd_q   <= s1_opnd_d;
            rd_data_q   <= rd_data_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

endmodule

// File: tb/tb_hv_core_pipe.sv
// tb/tb_hv_core_pipe.sv - randomized self-checking bench for hv_core_pipe against an ISA-level model
module tb_hv_core_pipe;

    localparam int DIM   = 16;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        gen_we;
    logic [3:0]  gen_addr;
    logic [15:0] gen_data;
    logic [15:0] sign_bit;

    hv_core_pipe_if #(.DIM(DIM)) bus ();

    hv_core_pipe #(.DIM(DIM), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .gen_we   (gen_we),
        .gen_addr (gen_addr),
        .gen_data (gen_data),
        .sign_bit (sign_bit),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Architectural model: program-order interpreter of the instruction set.
    logic [15:0] m_mem [16];
    logic [15:0] m_r1 = '0;
    logic [15:0] m_r2 = '0;
    logic [15:0] exp_q [$];
    int          exp_done = 0;
    int          done_cnt = 0;
    logic        rand_bp  = 1'b0;

    function automatic logic [15:0] mk(input int op, input int opnd);
        logic [3:0]  o;
        logic [11:0] d;
        o = op[3:0];
        d = opnd[11:0];
        return {o, d};
    endfunction

    task automatic model_exec(input logic [15:0] i);
        logic [3:0]  op;
        logic [3:0]  a;
        int          n;
        logic [31:0] dbl;
        op  = i[15:12];
        a   = i[3:0];
        n   = int'(i[11:0]) % DIM;
        dbl = {m_r2, m_r2};
        case (op)
            4'd1:  m_r2 = m_mem[a];
            4'd2:  m_r2 = m_r2 ^ m_mem[a];
            4'd3:  m_mem[a] = m_r2;
            4'd4:  begin dbl = dbl >> n; m_r2 = dbl[15:0];  end
            4'd5:  begin dbl = dbl << n; m_r2 = dbl[31:16]; end
            4'd6:  m_r2 = m_r1 ^ m_r2;
            4'd7:  m_r1 = m_r2;
            4'd8:  m_r2 = sign_bit;
            4'd9:  exp_q.push_back(m_r2);
            4'd10: exp_done++;
            default: ;
        endcase
    endtask

    task automatic model_clear();
        m_r1 = '0;
        m_r2 = '0;
        exp_q.delete();
    endtask

    // All tasks start and end at posedge+1.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [15:0] i);
        int n;
        n = 0;
        bus.inst_valid = 1'b1;
        bus.inst       = i;
        @(negedge clk);
        while (bus.inst_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.inst_valid = 1'b0;
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout inst=%h inst_ready=%b", i, bus.inst_ready);
        end else begin
            model_exec(i);
        end
    endtask

    task automatic gen_write(input logic [3:0] a, input logic [15:0] d);
        gen_we   = 1'b1;
        gen_addr = a;
        gen_data = d;
        @(posedge clk);
        #1;
        gen_we = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
        end
    endtask

    // Result monitor: every handshaked beat must match the model's next STORE.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected got=%h", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e) begin
                        errors++;
                        $display("FAIL out_data got=%h exp=%h", bus.out_data, e);
                    end
                end
            end else if (bus.out_valid !== 1'b1) begin
                checks++;
                if (bus.out_data !== 16'h0000) begin
                    errors++;
                    $display("FAIL out_data_idle got=%h exp=0000", bus.out_data);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) bus.out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic test_reset();
        rst_n          = 1'b1;
        run            = 1'b0;
        gen_we         = 1'b0;
        gen_addr       = '0;
        gen_data       = '0;
        sign_bit       = '0;
        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        bus.out_ready  = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.inst_ready !== 1'b0 || bus.out_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%b r=%b data=%h exp all 0",
                     bus.out_valid, bus.done, bus.inst_ready, bus.out_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run   = 1'b1;
        idle(2);
        @(negedge clk);
        checks++;
        if (bus.inst_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=1", bus.inst_ready);
        end
        @(posedge clk);
        #1;
        for (int a = 0; a < 16; a++) gen_write(a[3:0], 16'($urandom));
    endtask

    task automatic test_load_store();
        bus.out_ready = 1'b1;
        gen_write(4'd3, 16'hA5A5);
        issue(mk(1, 3));
        issue(mk(9, 0));
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_early got=%b exp=0", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hA5A5) begin
            errors++;
            $display("FAIL store_latency got v=%b data=%h exp v=1 data=a5a5", bus.out_valid, bus.out_data);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_one_beat got=%b exp=0", bus.out_valid);
        end
        @(posedge clk);
        #1;
        drain("load_store");
    endtask

    task automatic test_forwarding();
        bus.out_ready = 1'b1;
        gen_write(4'd5, 16'h00FF);
        gen_write(4'd6, 16'h1234);
        issue(mk(1, 6));
        issue(mk(3, 5));
        issue(mk(2, 5));
        issue(mk(9, 0));
        drain("forwarding");
    endtask

    task automatic test_rotation();
        bus.out_ready = 1'b1;
        gen_write(4'd7, 16'h0001);
        issue(mk(1, 7));
        issue(mk(4, 1));
        issue(mk(9, 0));
        issue(mk(5, 17));
        issue(mk(9, 0));
        issue(mk(4, 0));
        issue(mk(9, 0));
        issue(mk(5, 16'h0ABC));
        issue(mk(9, 0));
        drain("rotation");
    endtask

    task automatic test_back_pressure();
        bus.out_ready = 1'b0;
        gen_write(4'd8, 16'hAAAA);
        gen_write(4'd9, 16'h5555);
        issue(mk(1, 8));
        issue(mk(9, 0));
        issue(mk(1, 9));
        issue(mk(9, 0));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.inst_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0]) begin
                errors++;
                $display("FAIL bp_hold c=%0d got r=%b v=%b data=%h exp r=0 v=1 data=%h",
                         c, bus.inst_ready, bus.out_valid, bus.out_data, exp_q[0]);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        idle(2);
        @(negedge clk);
        checks++;
        if (bus.inst_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready got=%b exp=1", bus.inst_ready);
        end
        @(posedge clk);
        #1;
        drain("back_pressure");
    endtask

    task automatic test_last();
        int hs;
        int dn;
        int dcnt;
        hs   = -1;
        dn   = -1;
        dcnt = 0;
        bus.out_ready = 1'b0;
        gen_write(4'd11, 16'($urandom));
        issue(mk(1, 11));
        issue(mk(9, 0));
        issue(mk(10, 0));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.inst_ready !== 1'b0) begin
                errors++;
                $display("FAIL last_wait c=%0d got done=%b r=%b exp 0 0", c, bus.done, bus.inst_ready);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 && hs < 0) hs = t;
            if (bus.done === 1'b1) begin
                if (dn < 0) dn = t;
                dcnt++;
            end
        end
        checks++;
        if (hs < 0 || dn != hs + 2) begin
            errors++;
            $display("FAIL last_done_timing got hs=%0d done_at=%0d exp done_at=hs+2", hs, dn);
        end
        checks++;
        if (dcnt != 1) begin
            errors++;
            $display("FAIL last_done_width got=%0d exp=1", dcnt);
        end
        @(posedge clk);
        #1;
        drain("last");
    endtask

    task automatic test_gen_collision();
        bus.out_ready = 1'b1;
        issue(mk(1, 1));
        issue(mk(3, 2));
        // This gen write lands on the edge where the WB executes and must be dropped.
        gen_we   = 1'b1;
        gen_addr = 4'd10;
        gen_data = ~m_mem[10];
        @(posedge clk);
        #1;
        gen_we = 1'b0;
        issue(mk(1, 10));
        issue(mk(9, 0));
        issue(mk(1, 2));
        issue(mk(9, 0));
        drain("gen_collision");
    endtask

    task automatic test_soft_clear();
        bus.out_ready = 1'b0;
        gen_write(4'd4, 16'h0F0F);
        issue(mk(1, 4));
        issue(mk(7, 0));
        issue(mk(9, 0));
        idle(2);
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.inst_ready !== 1'b0) begin
            errors++;
            $display("FAIL soft_clear_ready got=%b exp=0", bus.inst_ready);
        end
        @(posedge clk);
        #1;
        model_clear();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL soft_clear_outputs got v=%b d=%b exp 0 0", bus.out_valid, bus.done);
        end
        @(posedge clk);
        #1;
        run = 1'b1;
        bus.out_ready = 1'b1;
        issue(mk(9, 0));
        issue(mk(1, 4));
        issue(mk(6, 0));
        issue(mk(9, 0));
        drain("soft_clear");
    endtask

    task automatic test_async_reset();
        logic [15:0] v;
        v = 16'($urandom);
        gen_write(4'd12, v);
        bus.out_ready = 1'b0;
        issue(mk(1, 13));
        issue(mk(9, 0));
        issue(mk(9, 0));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.inst_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%b r=%b exp 0 0 0", bus.out_valid, bus.done, bus.inst_ready);
        end
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        issue(mk(1, 12));
        issue(mk(9, 0));
        drain("async_reset");
    endtask

    task automatic test_random();
        int op;
        sign_bit = 16'($urandom);
        rand_bp  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            op = $urandom_range(0, 15);
            issue(mk(op, $urandom_range(0, 4095)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_bp = 1'b0;
        bus.out_ready = 1'b1;
        drain("random");
        idle(4);
        checks++;
        if (done_cnt != exp_done) begin
            errors++;
            $display("FAIL done_count got=%0d exp=%0d", done_cnt, exp_done);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_store();
        test_forwarding();
        test_rotation();
        test_back_pressure();
        test_last();
        test_gen_collision();
        test_soft_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
